// File: rtl/gelato_types.sv
// Shared types for the Gelato operand collector: instruction layout, register
// and warp widths, and the collector / operand-slot state encodings.
`ifndef COLLECTOR_NUM
`define COLLECTOR_NUM 4
`endif
`ifndef BANK_NUM
`define BANK_NUM 4
`endif

package gelato_types;
  localparam int COLLECTOR_W = (`COLLECTOR_NUM > 1) ? $clog2(`COLLECTOR_NUM) : 1;
  localparam int BANK_W      = (`BANK_NUM > 1) ? $clog2(`BANK_NUM) : 1;

  typedef logic [COLLECTOR_W-1:0] collector_num_t;
  typedef logic [BANK_W-1:0]      bank_num_t;
  typedef logic [4:0]             reg_num_t;
  typedef logic [2:0]             warp_num_t;
  typedef logic [63:0]            warp_reg_t;
  typedef logic [7:0]             opcode_t;

  typedef struct packed {
    opcode_t   opcode;
    warp_num_t warp_num;
    reg_num_t  rd;
    reg_num_t  rs1;
    reg_num_t  rs2;
    reg_num_t  rs3;
  } inst_t;

  typedef enum logic [1:0] {OPERAND_NEED, OPERAND_INFLIGHT, OPERAND_VALID} operand_state_t;
  typedef enum logic [1:0] {COLLECTOR_FREE, COLLECTOR_COLLECT, COLLECTOR_READY} collector_state_t;

  // Operand slot o reads rs1/rs2/rs3; slots beyond the third have no register.
  function automatic reg_num_t operand_reg(input inst_t inst, input int o);
    case (o)
      0:       return inst.rs1;
      1:       return inst.rs2;
      2:       return inst.rs3;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at ptr, and ptr moves
// just past the granted index when en is high.
module gelato_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end
endmodule

// File: rtl/gelato_operand_collector.sv
// Operand collector: buffers issued instructions, reads their source registers
// from single-port banks with per-bank round-robin arbitration, and dispatches
// complete entries round-robin.
module gelato_operand_collector
  import gelato_types::*;
#(
  parameter int NUM_COLLECTORS = 4,
  parameter int NUM_OPERANDS   = 3,
  parameter int NUM_BANKS      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                issue_valid,
  output logic                                issue_ready,
  input  inst_t                               issue_inst,
  input  logic      [NUM_OPERANDS-1:0]        issue_rs_used,
  output logic      [NUM_BANKS-1:0]           bank_req_valid,
  output reg_num_t  [NUM_BANKS-1:0]           bank_req_reg,
  output warp_num_t [NUM_BANKS-1:0]           bank_req_warp,
  input  warp_reg_t [NUM_BANKS-1:0]           bank_resp_data,
  output logic                                dispatch_valid,
  input  logic                                dispatch_ready,
  output inst_t                               dispatch_inst,
  output warp_reg_t [NUM_OPERANDS-1:0]        dispatch_data
);
  localparam int NUM_SLOTS = NUM_COLLECTORS * NUM_OPERANDS;
  localparam int CW = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Handshakes: a transfer happens on a clock edge where valid && ready; the
  // issuing side holds its payload while valid is high and ready is low.
  collector_state_t coll_state [NUM_COLLECTORS];
  collector_state_t coll_state_nxt [NUM_COLLECTORS];
  inst_t            coll_inst [NUM_COLLECTORS];
  operand_state_t   slot_state [NUM_SLOTS];
  operand_state_t   slot_state_nxt [NUM_SLOTS];
  warp_reg_t        slot_data [NUM_SLOTS];
  reg_num_t         slot_reg [NUM_SLOTS];
  warp_num_t        slot_warp [NUM_SLOTS];
  logic [BW-1:0]    slot_bank [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] bank_req [NUM_BANKS];
  logic [NUM_SLOTS-1:0] bank_grant [NUM_BANKS];
  logic [SW-1:0]        bank_gnt_idx [NUM_BANKS];
  logic                 cap_valid [NUM_BANKS];
  logic [SW-1:0]        cap_slot [NUM_BANKS];

  logic [NUM_COLLECTORS-1:0] disp_req;
  logic [NUM_COLLECTORS-1:0] disp_grant;
  logic [NUM_COLLECTORS-1:0] lock_grant;
  logic                      disp_lock;
  logic                      disp_fire;
  logic                      alloc_found;
  logic                      alloc;
  logic [CW-1:0]             alloc_idx;
  logic [NUM_COLLECTORS-1:0] all_valid_nxt;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_reg[s]  = operand_reg(coll_inst[s / NUM_OPERANDS], s % NUM_OPERANDS);
      slot_warp[s] = coll_inst[s / NUM_OPERANDS].warp_num;
      slot_bank[s] = BW'(slot_reg[s] + reg_num_t'(slot_warp[s])) & BW'(NUM_BANKS - 1);
    end
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      if (!alloc_found && coll_state[c] == COLLECTOR_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = CW'(c);
      end
    end
  end
  assign alloc = issue_valid && alloc_found;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_req[b] = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_req[b][s] = coll_state[s / NUM_OPERANDS] == COLLECTOR_COLLECT &&
                         slot_state[s] == OPERAND_NEED && slot_bank[s] == BW'(b);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_arb
    gelato_rr_arbiter #(.N(NUM_SLOTS)) u_bank_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (bank_req[b]),
      .en    (1'b1),
      .grant (bank_grant[b])
    );
  end

  // A held dispatch offer only re-presents the locked entry so that a newly
  // ready collector cannot displace it before dispatch_ready.
  assign disp_req = disp_lock ? lock_grant : disp_req_ready();

  function automatic logic [NUM_COLLECTORS-1:0] disp_req_ready();
    logic [NUM_COLLECTORS-1:0] r;
    for (int c = 0; c < NUM_COLLECTORS; c++) r[c] = coll_state[c] == COLLECTOR_READY;
    return r;
  endfunction

  gelato_rr_arbiter #(.N(NUM_COLLECTORS)) u_disp_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (disp_req),
    .en    (dispatch_ready),
    .grant (disp_grant)
  );
  assign disp_fire = dispatch_valid && dispatch_ready;

  // Next state of every operand slot: grant, then capture, then allocation.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_state_nxt[s] = slot_state[s];
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_grant[b][s]) slot_state_nxt[s] = OPERAND_INFLIGHT;
        if (cap_valid[b] && cap_slot[b] == SW'(s)) slot_state_nxt[s] = OPERAND_VALID;
      end
      if (alloc && alloc_idx == CW'(s / NUM_OPERANDS))
        slot_state_nxt[s] = issue_rs_used[s % NUM_OPERANDS] ? OPERAND_NEED : OPERAND_VALID;
    end
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      all_valid_nxt[c] = 1'b1;
      for (int o = 0; o < NUM_OPERANDS; o++)
        if (slot_state_nxt[c * NUM_OPERANDS + o] != OPERAND_VALID) all_valid_nxt[c] = 1'b0;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      coll_state_nxt[c] = coll_state[c];
      case (coll_state[c])
        COLLECTOR_FREE:
          if (alloc && alloc_idx == CW'(c))
            coll_state_nxt[c] = all_valid_nxt[c] ? COLLECTOR_READY : COLLECTOR_COLLECT;
        COLLECTOR_COLLECT:
          if (all_valid_nxt[c]) coll_state_nxt[c] = COLLECTOR_READY;
        COLLECTOR_READY:
          if (disp_fire && disp_grant[c]) coll_state_nxt[c] = COLLECTOR_FREE;
        default: coll_state_nxt[c] = COLLECTOR_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_COLLECTORS; c++) coll_state[c] <= COLLECTOR_FREE;
      for (int s = 0; s < NUM_SLOTS; s++) slot_state[s] <= OPERAND_VALID;
    end else begin
      for (int c = 0; c < NUM_COLLECTORS; c++) coll_state[c] <= coll_state_nxt[c];
      for (int s = 0; s < NUM_SLOTS; s++) slot_state[s] <= slot_state_nxt[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_COLLECTORS; c++) coll_inst[c] <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_data[s] <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        cap_valid[b] <= 1'b0;
        cap_slot[b]  <= '0;
      end
      disp_lock  <= 1'b0;
      lock_grant <= '0;
    end else begin
      for (int c = 0; c < NUM_COLLECTORS; c++)
        if (alloc && alloc_idx == CW'(c)) coll_inst[c] <= issue_inst;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int b = 0; b < NUM_BANKS; b++)
          if (cap_valid[b] && cap_slot[b] == SW'(s)) slot_data[s] <= bank_resp_data[b];
        if (alloc && alloc_idx == CW'(s / NUM_OPERANDS)) slot_data[s] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        cap_valid[b] <= |bank_grant[b];
        cap_slot[b]  <= bank_gnt_idx[b];
      end
      disp_lock  <= dispatch_valid && !dispatch_ready;
      lock_grant <= disp_grant;
    end
  end

  always_comb begin
    issue_ready    = alloc_found;
    dispatch_valid = |disp_grant;
    dispatch_inst  = '0;
    dispatch_data  = '0;
    for (int c = 0; c < NUM_COLLECTORS; c++) begin
      if (disp_grant[c]) begin
        dispatch_inst = coll_inst[c];
        for (int o = 0; o < NUM_OPERANDS; o++) dispatch_data[o] = slot_data[c * NUM_OPERANDS + o];
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req_valid[b] = |bank_grant[b];
      bank_req_reg[b]   = '0;
      bank_req_warp[b]  = '0;
      bank_gnt_idx[b]   = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (bank_grant[b][s]) begin
          bank_req_reg[b]  = slot_reg[s];
          bank_req_warp[b] = slot_warp[s];
          bank_gnt_idx[b]  = SW'(s);
        end
      end
    end
  end
endmodule

// File: tb/tb_gelato_operand_collector.sv
// Directed bench for gelato_operand_collector with a one-cycle-latency bank model.
module tb_gelato_operand_collector;
  import gelato_types::*;

  logic                    clk;
  logic                    rst;
  logic                    issue_valid;
  logic                    issue_ready;
  inst_t                   issue_inst;
  logic [2:0]              issue_rs_used;
  logic [3:0]              bank_req_valid;
  reg_num_t  [3:0]         bank_req_reg;
  warp_num_t [3:0]         bank_req_warp;
  warp_reg_t [3:0]         bank_resp_data;
  logic                    dispatch_valid;
  logic                    dispatch_ready;
  inst_t                   dispatch_inst;
  warp_reg_t [2:0]         dispatch_data;

  int checks = 0;
  int failures = 0;

  gelato_operand_collector #(
    .NUM_COLLECTORS(4), .NUM_OPERANDS(3), .NUM_BANKS(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_inst     (issue_inst),
    .issue_rs_used  (issue_rs_used),
    .bank_req_valid (bank_req_valid),
    .bank_req_reg   (bank_req_reg),
    .bank_req_warp  (bank_req_warp),
    .bank_resp_data (bank_resp_data),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_inst  (dispatch_inst),
    .dispatch_data  (dispatch_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic warp_reg_t mk(input int w, input int r);
    return {16'hC0DE, 8'(w), 8'(r), 16'h5A5A, 8'(r + w), 8'(r)};
  endfunction

  function automatic inst_t mk_inst(input int op, input int w, input int r1, input int r2, input int r3);
    inst_t i;
    i.opcode   = 8'(op);
    i.warp_num = 3'(w);
    i.rd       = 5'(op);
    i.rs1      = 5'(r1);
    i.rs2      = 5'(r2);
    i.rs3      = 5'(r3);
    return i;
  endfunction

  // Register banks answer one cycle after a request; idle banks drive junk.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      bank_resp_data[b] <= bank_req_valid[b] ? mk(int'(bank_req_warp[b]), int'(bank_req_reg[b]))
                                             : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input inst_t i, input logic [2:0] used);
    issue_valid   = 1'b1;
    issue_inst    = i;
    issue_rs_used = used;
    tick();
    issue_valid   = 1'b0;
    issue_inst    = '0;
    issue_rs_used = '0;
  endtask

  initial begin
    inst_t exp_inst [4];
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_inst = '0;
    issue_rs_used = '0;
    dispatch_ready = 1'b0;
    repeat (2) tick();
    check("rst_issue_ready", 256'(issue_ready), 256'(1));
    check("rst_disp_valid", 256'(dispatch_valid), 256'(0));
    check("rst_req_valid", 256'(bank_req_valid), 256'(0));
    check("rst_disp_inst", 256'(dispatch_inst), 256'(0));
    check("rst_disp_data", 256'(dispatch_data), 256'(0));
    rst = 1'b0;
    tick();

    // No-conflict instruction: banks 1/2/3 in t+1, dispatch in t+3
    issue(mk_inst(1, 0, 1, 2, 3), 3'b111);
    check("t1_req_valid", 256'(bank_req_valid), 256'(4'b1110));
    check("t1_req_reg", 256'(bank_req_reg), 256'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("t1_req_warp", 256'(bank_req_warp), 256'(0));
    check("t1_disp_t1", 256'(dispatch_valid), 256'(0));
    tick();
    check("t1_disp_t2", 256'(dispatch_valid), 256'(0));
    check("t1_req_t2", 256'(bank_req_valid), 256'(0));
    tick();
    check("t1_disp_t3", 256'(dispatch_valid), 256'(1));
    check("t1_inst", 256'(dispatch_inst), 256'(mk_inst(1, 0, 1, 2, 3)));
    check("t1_data", 256'(dispatch_data), 256'({mk(0, 3), mk(0, 2), mk(0, 1)}));
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    check("t1_disp_gone", 256'(dispatch_valid), 256'(0));

    // Bank-0 conflict: reg 4 then reg 8, dispatch in t+4
    issue(mk_inst(2, 0, 4, 8, 0), 3'b011);
    check("t2_req_valid_t1", 256'(bank_req_valid), 256'(4'b0001));
    check("t2_req_reg_t1", 256'(bank_req_reg[0]), 256'(4));
    tick();
    check("t2_req_valid_t2", 256'(bank_req_valid), 256'(4'b0001));
    check("t2_req_reg_t2", 256'(bank_req_reg[0]), 256'(8));
    check("t2_disp_t2", 256'(dispatch_valid), 256'(0));
    tick();
    check("t2_disp_t3", 256'(dispatch_valid), 256'(0));
    check("t2_req_t3", 256'(bank_req_valid), 256'(0));
    tick();
    check("t2_disp_t4", 256'(dispatch_valid), 256'(1));
    check("t2_data", 256'(dispatch_data), 256'({64'h0, mk(0, 8), mk(0, 4)}));
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;

    // No operands used: dispatch in t+1 with zero data
    issue(mk_inst(3, 1, 7, 7, 7), 3'b000);
    check("t3_disp_valid", 256'(dispatch_valid), 256'(1));
    check("t3_inst", 256'(dispatch_inst), 256'(mk_inst(3, 1, 7, 7, 7)));
    check("t3_data", 256'(dispatch_data), 256'(0));
    check("t3_req_valid", 256'(bank_req_valid), 256'(0));
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;

    // Fill all four collectors, then free one and reuse it
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 256'(issue_ready), 256'(1));
      issue(mk_inst(10 + i, 0, 0, 0, 0), 3'b000);
    end
    check("full_ready", 256'(issue_ready), 256'(0));
    issue(mk_inst(99, 0, 0, 0, 0), 3'b000);
    check("full_ignored", 256'(issue_ready), 256'(0));
    check("full_held_inst", 256'(dispatch_inst), 256'(mk_inst(10, 0, 0, 0, 0)));
    dispatch_ready = 1'b1;
    check("full_no_comb_ready", 256'(issue_ready), 256'(0));
    tick();
    dispatch_ready = 1'b0;
    check("freed_ready", 256'(issue_ready), 256'(1));
    check("freed_next_inst", 256'(dispatch_inst), 256'(mk_inst(11, 0, 0, 0, 0)));
    issue(mk_inst(14, 0, 0, 0, 0), 3'b000);
    dispatch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 256'(dispatch_valid), 256'(1));
      check("drain_inst", 256'(dispatch_inst), 256'(mk_inst(11 + i, 0, 0, 0, 0)));
      tick();
    end
    dispatch_ready = 1'b0;
    check("drain_empty", 256'(dispatch_valid), 256'(0));

    // Fresh pointers, then backpressure with three ready entries
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_inst[0] = mk_inst(20, 0, 1, 0, 0);
    exp_inst[1] = mk_inst(21, 1, 1, 0, 0);
    exp_inst[2] = mk_inst(22, 2, 5, 6, 0);
    issue(exp_inst[0], 3'b001);
    issue(exp_inst[1], 3'b001);
    issue(exp_inst[2], 3'b011);
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      check("hold_valid", 256'(dispatch_valid), 256'(1));
      check("hold_inst", 256'(dispatch_inst), 256'(exp_inst[0]));
      check("hold_data", 256'(dispatch_data), 256'({64'h0, 64'h0, mk(0, 1)}));
      tick();
    end
    dispatch_ready = 1'b1;
    check("rr0_inst", 256'(dispatch_inst), 256'(exp_inst[0]));
    tick();
    check("rr1_inst", 256'(dispatch_inst), 256'(exp_inst[1]));
    check("rr1_data", 256'(dispatch_data), 256'({64'h0, 64'h0, mk(1, 1)}));
    tick();
    check("rr2_inst", 256'(dispatch_inst), 256'(exp_inst[2]));
    check("rr2_data", 256'(dispatch_data), 256'({64'h0, mk(2, 6), mk(2, 5)}));
    tick();
    dispatch_ready = 1'b0;
    check("rr_empty", 256'(dispatch_valid), 256'(0));

    // Reset while a read is in flight: the late response must be dropped
    issue(mk_inst(30, 0, 1, 0, 0), 3'b001);
    check("mid_req_valid", 256'(bank_req_valid), 256'(4'b0010));
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("mid_rst_ready", 256'(issue_ready), 256'(1));
    check("mid_rst_disp", 256'(dispatch_valid), 256'(0));
    check("mid_rst_req", 256'(bank_req_valid), 256'(0));
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("post_rst_disp", 256'(dispatch_valid), 256'(0));
      check("post_rst_req", 256'(bank_req_valid), 256'(0));
    end
    check("post_rst_ready", 256'(issue_ready), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
